// File: rtl/data_mem_responder.sv
// Load/store memory responder: one request at a time, RV32I byte/half/word
// access rules, WAIT_STATES extra cycles, then a held response until accepted.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          in_range, f3_ok, align_ok, err, do_store;
  logic [31:0]   rd_word, rd_shift, load_val, wlane;
  logic [15:0]   rd_half;
  logic [3:0]    wmask;

  assign idx      = addr_q[AW+1:2];
  assign in_range = {2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS);
  assign rd_word  = in_range ? mem[idx] : '0;
  assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};
  assign rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    f3_ok = we_q ? (f3_q inside {3'd0, 3'd1, 3'd2})
                 : (f3_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (f3_q[1:0])
      2'd1:    align_ok = !addr_q[0];
      2'd2:    align_ok = (addr_q[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    err = !f3_ok || !align_ok || !in_range;

    case (f3_q)
      3'd0:    load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd4:    load_val = {24'd0, rd_shift[7:0]};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd5:    load_val = {16'd0, rd_half};
      default: load_val = rd_word;
    endcase

    // Store data is replicated across lanes; the mask picks the live ones.
    case (f3_q[1:0])
      2'd0: begin
        wmask = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        wmask = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  assign do_store = (state_q == WAIT) && (cnt_q == 4'd0) && we_q && !err;

  // Array is deliberately not reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (do_store)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            f3_q        <= req_f3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            // Loading WAIT_STATES gives accept-to-valid latency of 1+WAIT_STATES edges.
            cnt_q       <= 4'(WAIT_STATES);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err;
            rsp_rdata_q <= (err || we_q) ? 32'd0 : load_val;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-addressed memory model.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int WS    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errs   = 0;

  logic        exp_active = 1'b0;
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [7:0]  mb [0:DEPTH*4-1];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: byte-granular memory, access size 1<<f3[1:0].
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int n, base;
    logic [31:0] v;
    n   = 1 << f3[1:0];
    err = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (n == 2 && a % 2 != 0) err = 1'b1;
    if (n == 4 && a % 4 != 0) err = 1'b1;
    if (a >= 32'(DEPTH * 4)) err = 1'b1;
    rd = 32'd0;
    if (!err) begin
      base = int'(a);
      if (we) begin
        for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rd = v;
      end
    end
  endfunction

  // Response checker: every cycle a response is presented it must match the model.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      checks++;
      if (!exp_active) begin
        errs++;
        $display("FAIL spurious_rsp: got rsp_valid=1 want 0");
      end else if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
        errs++;
        $display("FAIL rsp_data: got rdata=%h err=%b want rdata=%h err=%b",
                 rsp_rdata, rsp_err, exp_rdata, exp_err);
      end
    end
  end

  // One transaction, entered and left at a negedge. bp forces that many
  // rsp_ready=0 cycles while a further request is held on the bus.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int bp,
                      input logic lit, input logic [31:0] lit_rd, input logic lit_err);
    logic [31:0] mr;
    logic me;
    int k, n;
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    k = 0;
    while (!req_ready) begin
      @(negedge clk);
      k++;
      if (k > 20) begin
        chk("accept_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    model(we, f3, addr, wd, mr, me);
    if (lit) begin
      chk("model_rdata", mr, lit_rd);
      chk("model_err", 32'(me), 32'(lit_err));
    end
    exp_rdata = mr; exp_err = me; exp_active = 1'b1;
    @(posedge clk);
    k = 0;
    while (1) begin
      @(negedge clk);
      if (bp == 0) req_valid = 1'b0;
      if (rsp_valid || k > 40) break;
      k++;
    end
    chk("latency", 32'(k), 32'(1 + WS));
    if (!rsp_valid) begin
      exp_active = 1'b0; req_valid = 1'b0;
      return;
    end
    n = 0;
    while (1) begin
      if (n < bp) begin
        rsp_ready = 1'b0;
        chk("bp_req_ready", 32'(req_ready), 32'd0);
      end else begin
        rsp_ready = ($urandom_range(0, 2) != 0);
      end
      @(posedge clk);
      n++;
      if (rsp_ready || n > 200) break;
      @(negedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0; exp_active = 1'b0;
    chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'd2;
    req_addr = 32'h10; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);

    for (int w = 0; w < 16; w++) xact(1'b1, 3'd2, 32'(w * 4), $urandom, 0, 1'b0, 32'd0, 1'b0);

    xact(1'b1, 3'd2, 32'h10, 32'h8BADF00D, 0, 1'b1, 32'd0, 1'b0);
    xact(1'b0, 3'd2, 32'h10, 32'd0, 0, 1'b1, 32'h8BADF00D, 1'b0);
    xact(1'b1, 3'd0, 32'h13, 32'h000000A5, 0, 1'b1, 32'd0, 1'b0);
    xact(1'b1, 3'd1, 32'h10, 32'h00001234, 0, 1'b1, 32'd0, 1'b0);
    xact(1'b0, 3'd2, 32'h10, 32'd0, 0, 1'b1, 32'hA5AD1234, 1'b0);
    xact(1'b0, 3'd0, 32'h13, 32'd0, 0, 1'b1, 32'hFFFFFFA5, 1'b0);
    xact(1'b0, 3'd4, 32'h13, 32'd0, 0, 1'b1, 32'h000000A5, 1'b0);
    xact(1'b0, 3'd1, 32'h12, 32'd0, 0, 1'b1, 32'hFFFFA5AD, 1'b0);

    xact(1'b0, 3'd1, 32'h11, 32'd0, 0, 1'b1, 32'd0, 1'b1);
    xact(1'b1, 3'd2, 32'h12, 32'hFFFFFFFF, 0, 1'b1, 32'd0, 1'b1);
    xact(1'b0, 3'd3, 32'h10, 32'd0, 0, 1'b1, 32'd0, 1'b1);
    xact(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 0, 1'b1, 32'd0, 1'b1);
    xact(1'b0, 3'd2, 32'h400, 32'd0, 0, 1'b1, 32'd0, 1'b1);
    xact(1'b0, 3'd2, 32'h10, 32'd0, 0, 1'b1, 32'hA5AD1234, 1'b0);

    xact(1'b0, 3'd2, 32'h10, 32'd0, 5, 1'b1, 32'hA5AD1234, 1'b0);
    xact(1'b0, 3'd5, 32'h12, 32'd0, 0, 1'b1, 32'h0000A5AD, 1'b0);

    // Reset during WAIT must drop the pending store.
    xact(1'b1, 3'd2, 32'h20, 32'h11111111, 0, 1'b1, 32'd0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    chk("pre_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midwait_req_ready", 32'(req_ready), 32'd0);
    chk("midwait_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midwait_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xact(1'b0, 3'd2, 32'h20, 32'd0, 0, 1'b1, 32'h11111111, 1'b0);

    for (int t = 0; t < 300; t++) begin
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 32'h400 + $urandom_range(0, 4095);
      else                           a = 32'($urandom_range(0, 63));
      xact(1'($urandom_range(0, 1)), f, a, $urandom, $urandom_range(0, 3), 1'b0, 32'd0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
